// File: rtl/clock_div_ctrl.sv
// Runtime-programmable glitch-free clock divider: outclk half-period loaded over valid/ready.
// Optional CLOCK_DIV_CTRL_TICK_EN adds a one-cycle tick coincident with each outclk rise.
module clock_div_ctrl #(
  parameter int unsigned C_IN_FREQ  = 100000,
  parameter int unsigned C_OUT_FREQ = 60
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cfg_valid,
  input  logic [31:0] cfg_half,
  output logic        cfg_ready,
  output logic        cfg_err,
  output logic        outclk,
  output logic        running,
`ifdef CLOCK_DIV_CTRL_TICK_EN
  output logic        tick,
`endif
  output logic [31:0] active_half
);

  localparam logic [31:0] H0 = 32'(C_IN_FREQ / (2 * C_OUT_FREQ));

  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_t;

  state_t      state_reg;
  logic [31:0] count_reg;
  logic [31:0] pending_half_reg;
  logic        pending_reg;

  logic xfer;
  logic xfer_ok;
  logic phase_end;
  logic fall;
  logic rise;

  assign xfer      = cfg_valid && !pending_reg;
  assign xfer_ok   = xfer && (cfg_half != 32'd0);
  assign phase_end = (count_reg == active_half - 32'd1);
  assign fall      = (state_reg != STOP) && outclk && phase_end;
  assign rise      = (state_reg == RUN) && !outclk && phase_end;

  assign cfg_ready = !pending_reg;
  assign running   = (state_reg != STOP);

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg        <= STOP;
      count_reg        <= 32'd0;
      outclk           <= 1'b0;
      active_half      <= H0;
      pending_half_reg <= 32'd0;
      pending_reg      <= 1'b0;
      cfg_err          <= 1'b0;
`ifdef CLOCK_DIV_CTRL_TICK_EN
      tick             <= 1'b0;
`endif
    end else begin
      cfg_err <= xfer && (cfg_half == 32'd0);
`ifdef CLOCK_DIV_CTRL_TICK_EN
      tick    <= 1'b0;
`endif
      case (state_reg)
        STOP: begin
          count_reg <= 32'd0;
          outclk    <= 1'b0;
          // A value accepted on the cycle we entered STOP is still pending; flush it here.
          if (pending_reg) begin
            active_half <= pending_half_reg;
            pending_reg <= 1'b0;
          end else if (xfer_ok) begin
            active_half <= cfg_half;
          end
          if (enable) state_reg <= RUN;
        end
        RUN, DRAIN: begin
          if (xfer_ok) begin
            pending_half_reg <= cfg_half;
            pending_reg      <= 1'b1;
          end
          if (state_reg == RUN && !enable && !outclk) begin
            state_reg <= STOP;
            count_reg <= 32'd0;
            if (pending_reg) begin
              active_half <= pending_half_reg;
              pending_reg <= 1'b0;
            end
          end else if (fall) begin
            outclk    <= 1'b0;
            count_reg <= 32'd0;
            state_reg <= enable ? RUN : STOP;
            if (pending_reg) begin
              active_half <= pending_half_reg;
              pending_reg <= 1'b0;
            end
          end else if (rise) begin
            outclk    <= 1'b1;
            count_reg <= 32'd0;
`ifdef CLOCK_DIV_CTRL_TICK_EN
            tick      <= 1'b1;
`endif
          end else begin
            // Mid-phase: a drained high phase resumes in RUN without disturbing count.
            count_reg <= count_reg + 32'd1;
            state_reg <= enable ? RUN : DRAIN;
          end
        end
        default: state_reg <= STOP;
      endcase
    end
  end

endmodule

// File: doc/clock_div_ctrl.md
# clock_div_ctrl

Runtime-programmable clock-divider controller that generates `outclk` from `refclk` with a half-period loaded through a valid/ready configuration port. It sequences start, stop and ratio changes so `outclk` never produces a runt high or low phase: changes are applied only at a falling `outclk` edge or while stopped. It sits between the register/control logic and the logic clocked or enabled by the divided clock, replacing fixed-ratio dividers wherever the rate must change at run time.

## Interface
- C_IN_FREQ, 100000: refclk frequency in the team's frequency unit; used only for the reset half-period.
- C_OUT_FREQ, 60: reset output frequency; reset half-period H0 = C_IN_FREQ/(2*C_OUT_FREQ), integer division, must be ≥1.
- refclk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- enable  in  1  level; high requests `outclk` to run, low requests a clean stop.
- cfg_valid  in  1  new half-period offered.
- cfg_half  in  32  requested half-period in refclk cycles; 0 is illegal.
- cfg_ready  out  1  controller can accept `cfg_half`.
- cfg_err  out  1  one-cycle pulse: a zero `cfg_half` was accepted and discarded.
- outclk  out  1  divided clock, registered.
- running  out  1  high when state ≠ STOP.
- active_half  out  32  half-period currently in force.
- tick  out  1  present only with CLOCK_DIV_CTRL_TICK_EN; see Configuration.

## Operation
- Registers: 32-bit `count`, `active_half`, `pending_half`, `pending` flag, `outclk`, state ∈ {STOP, RUN, DRAIN}.
- Reset: state STOP, `count`=0, `outclk`=0, `active_half`=H0, `pending`=0, `cfg_ready`=1, `cfg_err`=0, `running`=0, `tick`=0. Reset overrides every other input in the same cycle.
- `cfg_ready` = !`pending`. A transfer happens on a cycle with `cfg_valid` && `cfg_ready`.
- Transfer with `cfg_half`=0: the value is discarded, `cfg_err` is 1 the next cycle, and nothing else changes.
- Transfer in STOP: `active_half` takes the value the next cycle, and `pending` stays 0.
- Transfer in RUN or DRAIN: the value goes into `pending_half`, and `pending` becomes 1.
- Fall event: RUN or DRAIN, `outclk`=1 and `count`=`active_half`−1.
- Rise event: RUN, `outclk`=0 and `count`=`active_half`−1.
- Fall event behaviour:
  - `outclk` becomes 0 and `count` becomes 0.
  - If `pending` is set, `active_half` takes `pending_half` and `pending` clears, in the same edge.
- Rise event behaviour: `outclk` becomes 1 and `count` becomes 0.
- Otherwise in RUN or DRAIN, `count` increments. In STOP, `count` holds 0.
- STOP→RUN when `enable`=1. Counting starts from 0, and the first rise comes `active_half` cycles after entry.
- RUN→DRAIN when `enable`=0 and `outclk`=1.
- RUN→STOP when `enable`=0 and `outclk`=0. `count` becomes 0, and any pending value is applied immediately.
- DRAIN→RUN when `enable`=1. `count` and `outclk` are undisturbed.
- DRAIN→STOP on the fall event. `outclk` therefore always rests at 0 in STOP.
- Comparisons are unsigned 32-bit. `count` never exceeds `active_half`−1, so there is no wrap-around.

## Timing
- Each `outclk` phase lasts exactly `active_half` refclk cycles, including the first phase after start.
- A new ratio takes effect at the first fall event after acceptance.
- A transfer on the same cycle as a fall event applies at the next fall event, not the current one.
- `cfg_ready` reasserts the cycle after the applying fall event.
- Stop latency is at most `active_half` cycles, counted from `enable` low to `running` low.
- `outclk`, `running`, `cfg_ready`, `cfg_err` and `active_half` are all registered or derived only from registers; there are no combinational paths from inputs.
- Reset mid-phase: `outclk` is 0 on the next cycle. This is the only case where a phase may be truncated.

## Configuration
- CLOCK_DIV_CTRL_TICK_EN defined: the `tick` port exists. It is a registered one-cycle pulse coincident with each rising edge of `outclk`, and serves as a clock-enable for logic kept in the refclk domain.
- Not defined: the `tick` port and its register are omitted. All other behaviour is identical.

## Test plan
- Run from reset: C_IN_FREQ=1200, C_OUT_FREQ=60 (H0=10), `enable`=1 from cycle 0 → `outclk` first rises 10 cycles after RUN entry, then toggles every 10 cycles, and `active_half`=10.
- Ratio change: while running, transfer `cfg_half`=4 mid-high-phase → `cfg_ready`=0 until the fall, the high phase still lasts 10 cycles, subsequent phases last 4, and `active_half`=4 after the fall.
- Zero config: transfer `cfg_half`=0 in RUN → `cfg_err` pulses for 1 cycle, `active_half` stays 10, and `cfg_ready` stays 1.
- Clean stop: drop `enable` 3 cycles into a high phase → `outclk` stays high 7 more cycles, falls, and `running`=0 on that same edge. Drop `enable` during a low phase → STOP on the next cycle.
- Stop with pending plus restart: transfer 6 during the high phase, then drop `enable` → the value is applied at the fall. Re-enable → phases of 6. Re-enable during DRAIN → no glitch, and the original phase length is kept.
- Reset mid-operation plus tick (with CLOCK_DIV_CTRL_TICK_EN): assert `rst` while `outclk`=1 → next cycle `outclk`=0, `active_half`=10, `cfg_ready`=1. `tick` pulses exactly once per `outclk` rise, and never in STOP.
